// File: rtl/common_types_pkg.sv
// Shared AHB-Lite types and helpers for the two-master arbiter.
package common_types_pkg;

    // AHB-Lite transfer type encoding.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Which upstream port owns an address or data phase.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } arb_owner_t;

    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;

    // NONSEQ and SEQ move data; IDLE and BUSY do not.
    function automatic logic htrans_is_xfer(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_bus_if.sv
// AHB-Lite bus bundle; the master modport drives address/control/write data.
interface ahb_bus_if;
    import common_types_pkg::*;

    logic [AHB_AW-1:0] haddr;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    htrans_t           htrans;
    logic              hwrite;
    logic [AHB_DW-1:0] hwdata;
    logic [AHB_DW-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, hsize, hburst, htrans, hwrite, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hsize, hburst, htrans, hwrite, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Two-input winner selection: a lone requester wins; a tie goes to the
// port not last granted when en=1, otherwise to m0.
module ahb_rr_pick
    import common_types_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t lg,
    input  logic       en,
    output arb_owner_t winner
);

    // Pick a winner from the current request vector.
    always_comb begin
        winner = OWNER_NONE;
        case (req)
            2'b01:   winner = OWNER_M0;
            2'b10:   winner = OWNER_M1;
            2'b11:   winner = (en && (lg == OWNER_M0)) ? OWNER_M1 : OWNER_M0;
            default: winner = OWNER_NONE;
        endcase
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter onto one shared bus. No data is buffered:
// address/control is muxed by the combinational next grant, write data
// and responses follow the registered data-phase owner.
module ahb_arbiter
    import common_types_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic      CLK,
    input  logic      nRST,
    ahb_bus_if.slave  m0,
    ahb_bus_if.slave  m1,
    ahb_bus_if.master s
);

    arb_owner_t r_ag;   // owner of the last accepted address phase
    arb_owner_t r_dp;   // owner of the data phase in progress
    arb_owner_t r_lg;   // last port granted a NONSEQ

    logic [1:0] w_req;
    arb_owner_t w_pick;
    arb_owner_t w_ng;
    htrans_t    w_ag_trans;
    htrans_t    w_sel_trans;
    logic       w_lock;

    assign w_req = {htrans_is_xfer(m1.htrans), htrans_is_xfer(m0.htrans)};

    ahb_rr_pick u_pick (
        .req    (w_req),
        .lg     (r_lg),
        .en     (RR_EN),
        .winner (w_pick)
    );

    // Next grant: held during wait states and inside a burst (SEQ/BUSY),
    // forced to NONE while reset is asserted so outputs go idle at once.
    always_comb begin
        w_ag_trans = (r_ag == OWNER_M0) ? m0.htrans :
                     (r_ag == OWNER_M1) ? m1.htrans : HTRANS_IDLE;
        w_lock     = (w_ag_trans == HTRANS_SEQ) || (w_ag_trans == HTRANS_BUSY);
        if (!nRST)
            w_ng = OWNER_NONE;
        else if (!s.hready || w_lock)
            w_ng = r_ag;
        else
            w_ng = w_pick;
    end

    // Address/control mux from the next-grant port; idle bus when NONE.
    always_comb begin
        s.haddr     = '0;
        s.hsize     = '0;
        s.hburst    = '0;
        s.hwrite    = 1'b0;
        w_sel_trans = HTRANS_IDLE;
        case (w_ng)
            OWNER_M0: begin
                s.haddr     = m0.haddr;
                s.hsize     = m0.hsize;
                s.hburst    = m0.hburst;
                s.hwrite    = m0.hwrite;
                w_sel_trans = m0.htrans;
            end
            OWNER_M1: begin
                s.haddr     = m1.haddr;
                s.hsize     = m1.hsize;
                s.hburst    = m1.hburst;
                s.hwrite    = m1.hwrite;
                w_sel_trans = m1.htrans;
            end
            default: ;
        endcase
        s.htrans = w_sel_trans;
    end

    // Write data follows the data-phase owner.
    always_comb begin
        s.hwdata = '0;
        case (r_dp)
            OWNER_M0: s.hwdata = m0.hwdata;
            OWNER_M1: s.hwdata = m1.hwdata;
            default:  s.hwdata = '0;
        endcase
    end

    // Read data is broadcast; the error response goes to the data owner only.
    always_comb begin
        m0.hrdata = s.hrdata;
        m1.hrdata = s.hrdata;
        m0.hresp  = (r_dp == OWNER_M0) ? s.hresp : 1'b0;
        m1.hresp  = (r_dp == OWNER_M1) ? s.hresp : 1'b0;
    end

    // Per-port ready: follow the bus when involved, stall a losing requester.
    always_comb begin
        m0.hready = 1'b1;
        m1.hready = 1'b1;
        if (nRST) begin
            if ((r_dp == OWNER_M0) || (w_ng == OWNER_M0))
                m0.hready = s.hready;
            else if (w_req[0])
                m0.hready = 1'b0;
            if ((r_dp == OWNER_M1) || (w_ng == OWNER_M1))
                m1.hready = s.hready;
            else if (w_req[1])
                m1.hready = 1'b0;
        end
    end

    // Grant, data-phase and last-grant registers advance only when the bus is ready.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ag <= OWNER_NONE;
            r_dp <= OWNER_NONE;
            r_lg <= OWNER_M1;
        end else if (s.hready) begin
            r_ag <= w_ng;
            r_dp <= htrans_is_xfer(w_sel_trans) ? w_ng : OWNER_NONE;
            if (w_sel_trans == HTRANS_NONSEQ)
                r_lg <= w_ng;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: one round-robin instance and one
// fixed-priority instance, each with its own bus bundles.
module tb_ahb_arbiter;
    import common_types_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ahb_bus_if m0_if ();
    ahb_bus_if m1_if ();
    ahb_bus_if s_if ();
    ahb_bus_if m0b_if ();
    ahb_bus_if m1b_if ();
    ahb_bus_if sb_if ();

    ahb_arbiter #(.RR_EN(1'b1)) u_dut (
        .CLK (clk), .nRST (nrst), .m0 (m0_if), .m1 (m1_if), .s (s_if)
    );

    ahb_arbiter #(.RR_EN(1'b0)) u_dut_fp (
        .CLK (clk), .nRST (nrst), .m0 (m0b_if), .m1 (m1b_if), .s (sb_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input htrans_t t, input logic [31:0] a, input logic w,
                            input logic [2:0] b, input logic [31:0] wd);
        m0_if.htrans = t; m0_if.haddr = a; m0_if.hwrite = w;
        m0_if.hburst = b; m0_if.hsize = 3'd2; m0_if.hwdata = wd;
    endtask

    task automatic drive_m1(input htrans_t t, input logic [31:0] a, input logic w,
                            input logic [2:0] b, input logic [31:0] wd);
        m1_if.htrans = t; m1_if.haddr = a; m1_if.hwrite = w;
        m1_if.hburst = b; m1_if.hsize = 3'd2; m1_if.hwdata = wd;
    endtask

    task automatic drive_slave(input logic rdy, input logic [31:0] rd, input logic resp);
        s_if.hready = rdy; s_if.hrdata = rd; s_if.hresp = resp;
    endtask

    task automatic drive_fp(input htrans_t t0, input logic [31:0] a0,
                            input htrans_t t1, input logic [31:0] a1);
        m0b_if.htrans = t0; m0b_if.haddr = a0; m0b_if.hwrite = 1'b0;
        m0b_if.hburst = 3'd0; m0b_if.hsize = 3'd2; m0b_if.hwdata = '0;
        m1b_if.htrans = t1; m1b_if.haddr = a1; m1b_if.hwrite = 1'b0;
        m1b_if.hburst = 3'd0; m1b_if.hsize = 3'd2; m1b_if.hwdata = '0;
    endtask

    task automatic all_idle();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_slave(1'b1, 32'h0, 1'b0);
        drive_fp(HTRANS_IDLE, 32'h0, HTRANS_IDLE, 32'h0);
        sb_if.hready = 1'b1; sb_if.hrdata = '0; sb_if.hresp = 1'b0;
    endtask

    task automatic apply_reset();
        step();
        all_idle();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
    endtask

    // Reset with both masters requesting: bus must stay idle, ports ready.
    task automatic test_reset();
        drive_m0(HTRANS_NONSEQ, 32'h1234, 1'b1, 3'd0, 32'h55);
        drive_m1(HTRANS_NONSEQ, 32'h5678, 1'b0, 3'd0, 32'h66);
        drive_slave(1'b1, 32'h0, 1'b1);
        step();
        #3;
        $display("txn reset with both masters requesting");
        checks++; if (s_if.htrans !== HTRANS_IDLE) begin failures++; $display("FAIL rst_htrans got=%0d want=%0d", s_if.htrans, HTRANS_IDLE); end
        checks++; if (s_if.haddr !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h want=%h", s_if.haddr, 32'h0); end
        checks++; if (s_if.hwdata !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h want=%h", s_if.hwdata, 32'h0); end
        checks++; if (s_if.hwrite !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b want=0", s_if.hwrite); end
        checks++; if (m0_if.hready !== 1'b1) begin failures++; $display("FAIL rst_m0_hready got=%b want=1", m0_if.hready); end
        checks++; if (m1_if.hready !== 1'b1) begin failures++; $display("FAIL rst_m1_hready got=%b want=1", m1_if.hready); end
        checks++; if (m0_if.hresp !== 1'b0 || m1_if.hresp !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%b%b want=00", m0_if.hresp, m1_if.hresp); end
        step();
        all_idle();
        nrst = 1'b1;
    endtask

    // m0 single read, zero-wait slave.
    task automatic test_single_read();
        step();
        drive_m0(HTRANS_NONSEQ, 32'h0000_0100, 1'b0, 3'd0, 32'h0);
        #3;
        $display("txn m0 read 0x00000100");
        checks++; if (s_if.haddr !== 32'h100) begin failures++; $display("FAIL rd_haddr got=%h want=%h", s_if.haddr, 32'h100); end
        checks++; if (s_if.htrans !== HTRANS_NONSEQ) begin failures++; $display("FAIL rd_htrans got=%0d want=%0d", s_if.htrans, HTRANS_NONSEQ); end
        checks++; if (m0_if.hready !== 1'b1) begin failures++; $display("FAIL rd_m0_hready_a got=%b want=1", m0_if.hready); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_slave(1'b1, 32'hCAFE_0001, 1'b0);
        #3;
        checks++; if (m0_if.hrdata !== 32'hCAFE_0001) begin failures++; $display("FAIL rd_hrdata got=%h want=%h", m0_if.hrdata, 32'hCAFE_0001); end
        checks++; if (m0_if.hready !== 1'b1) begin failures++; $display("FAIL rd_m0_hready_d got=%b want=1", m0_if.hready); end
        checks++; if (s_if.htrans !== HTRANS_IDLE) begin failures++; $display("FAIL rd_idle_after got=%0d want=%0d", s_if.htrans, HTRANS_IDLE); end
        step();
        drive_slave(1'b1, 32'h0, 1'b0);
    endtask

    // Simultaneous requests after reset alternate m0, m1, m0.
    task automatic test_alternation();
        apply_reset();
        step();
        drive_m0(HTRANS_NONSEQ, 32'h10, 1'b0, 3'd0, 32'h0);
        drive_m1(HTRANS_NONSEQ, 32'h20, 1'b0, 3'd0, 32'h0);
        #3;
        $display("txn tie m0 0x10 vs m1 0x20");
        checks++; if (s_if.haddr !== 32'h10) begin failures++; $display("FAIL alt1_haddr got=%h want=%h", s_if.haddr, 32'h10); end
        checks++; if (m0_if.hready !== 1'b1) begin failures++; $display("FAIL alt1_m0_hready got=%b want=1", m0_if.hready); end
        checks++; if (m1_if.hready !== 1'b0) begin failures++; $display("FAIL alt1_m1_hready got=%b want=0", m1_if.hready); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h20) begin failures++; $display("FAIL alt2_haddr got=%h want=%h", s_if.haddr, 32'h20); end
        checks++; if (m1_if.hready !== 1'b1) begin failures++; $display("FAIL alt2_m1_hready got=%b want=1", m1_if.hready); end
        step();
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        step();
        drive_m0(HTRANS_NONSEQ, 32'h30, 1'b0, 3'd0, 32'h0);
        drive_m1(HTRANS_NONSEQ, 32'h40, 1'b0, 3'd0, 32'h0);
        #3;
        $display("txn tie m0 0x30 vs m1 0x40");
        checks++; if (s_if.haddr !== 32'h30) begin failures++; $display("FAIL alt3_haddr got=%h want=%h", s_if.haddr, 32'h30); end
        checks++; if (m1_if.hready !== 1'b0) begin failures++; $display("FAIL alt3_m1_hready got=%b want=0", m1_if.hready); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h40) begin failures++; $display("FAIL alt4_haddr got=%h want=%h", s_if.haddr, 32'h40); end
        step();
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    // Fixed priority: m0 wins every tie, m1 stays stalled.
    task automatic test_fixed_priority();
        for (int k = 0; k < 4; k++) begin
            step();
            drive_fp(HTRANS_NONSEQ, 32'h100 + 32'(4 * k), HTRANS_NONSEQ, 32'h200);
            #3;
            $display("txn fixed-priority tie beat %0d", k);
            checks++; if (sb_if.haddr !== 32'h100 + 32'(4 * k)) begin failures++; $display("FAIL fp_haddr beat=%0d got=%h want=%h", k, sb_if.haddr, 32'h100 + 32'(4 * k)); end
            checks++; if (m1b_if.hready !== 1'b0) begin failures++; $display("FAIL fp_m1_hready beat=%0d got=%b want=0", k, m1b_if.hready); end
            checks++; if (m0b_if.hready !== 1'b1) begin failures++; $display("FAIL fp_m0_hready beat=%0d got=%b want=1", k, m0b_if.hready); end
        end
        step();
        drive_fp(HTRANS_IDLE, 32'h0, HTRANS_IDLE, 32'h0);
    endtask

    // m1 write with two slave wait states while m0 waits for the bus.
    task automatic test_wait_states();
        step();
        drive_m1(HTRANS_NONSEQ, 32'h2000, 1'b1, 3'd0, 32'h0);
        #3;
        $display("txn m1 write 0xDEADBEEF to 0x2000, 2 waits");
        checks++; if (s_if.haddr !== 32'h2000 || s_if.hwrite !== 1'b1) begin failures++; $display("FAIL ws_addr got=%h/%b want=%h/1", s_if.haddr, s_if.hwrite, 32'h2000); end
        for (int w = 0; w < 2; w++) begin
            step();
            drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'hDEAD_BEEF);
            drive_m0(HTRANS_NONSEQ, 32'h3000, 1'b0, 3'd0, 32'h0);
            drive_slave(1'b0, 32'h0, 1'b0);
            #3;
            checks++; if (s_if.htrans !== HTRANS_IDLE || s_if.haddr !== 32'h0) begin failures++; $display("FAIL ws_bus_held wait=%0d got=%0d/%h want=%0d/%h", w, s_if.htrans, s_if.haddr, HTRANS_IDLE, 32'h0); end
            checks++; if (s_if.hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ws_hwdata wait=%0d got=%h want=%h", w, s_if.hwdata, 32'hDEAD_BEEF); end
            checks++; if (m0_if.hready !== 1'b0 || m1_if.hready !== 1'b0) begin failures++; $display("FAIL ws_hready wait=%0d got=%b%b want=00", w, m0_if.hready, m1_if.hready); end
        end
        step();
        drive_slave(1'b1, 32'h0, 1'b0);
        #3;
        checks++; if (s_if.haddr !== 32'h3000) begin failures++; $display("FAIL ws_m0_addr got=%h want=%h", s_if.haddr, 32'h3000); end
        checks++; if (s_if.hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ws_last_hwdata got=%h want=%h", s_if.hwdata, 32'hDEAD_BEEF); end
        checks++; if (m0_if.hready !== 1'b1) begin failures++; $display("FAIL ws_m0_hready got=%b want=1", m0_if.hready); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0BAD_F00D);
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        #3;
        checks++; if (s_if.hwdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL ws_overlap_hwdata got=%h want=%h", s_if.hwdata, 32'h0BAD_F00D); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    // m0 INCR4 (with one BUSY) keeps the bus while m1 waits.
    task automatic test_burst();
        step();
        drive_m0(HTRANS_NONSEQ, 32'h400, 1'b0, 3'd3, 32'h0);
        #3;
        $display("txn m0 INCR4 from 0x400, m1 contending");
        checks++; if (s_if.haddr !== 32'h400 || s_if.hburst !== 3'd3) begin failures++; $display("FAIL bu_first got=%h/%0d want=%h/3", s_if.haddr, s_if.hburst, 32'h400); end
        step();
        drive_m0(HTRANS_SEQ, 32'h404, 1'b0, 3'd3, 32'h0);
        drive_m1(HTRANS_NONSEQ, 32'h500, 1'b0, 3'd0, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h404 || m1_if.hready !== 1'b0) begin failures++; $display("FAIL bu_beat2 got=%h/%b want=%h/0", s_if.haddr, m1_if.hready, 32'h404); end
        step();
        drive_m0(HTRANS_BUSY, 32'h408, 1'b0, 3'd3, 32'h0);
        #3;
        checks++; if (s_if.htrans !== HTRANS_BUSY || m1_if.hready !== 1'b0) begin failures++; $display("FAIL bu_busy got=%0d/%b want=%0d/0", s_if.htrans, m1_if.hready, HTRANS_BUSY); end
        step();
        drive_m0(HTRANS_SEQ, 32'h408, 1'b0, 3'd3, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h408 || m1_if.hready !== 1'b0) begin failures++; $display("FAIL bu_beat3 got=%h/%b want=%h/0", s_if.haddr, m1_if.hready, 32'h408); end
        step();
        drive_m0(HTRANS_SEQ, 32'h40C, 1'b0, 3'd3, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h40C || m1_if.hready !== 1'b0) begin failures++; $display("FAIL bu_beat4 got=%h/%b want=%h/0", s_if.haddr, m1_if.hready, 32'h40C); end
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        #3;
        checks++; if (s_if.haddr !== 32'h500 || m1_if.hready !== 1'b1) begin failures++; $display("FAIL bu_m1_after got=%h/%b want=%h/1", s_if.haddr, m1_if.hready, 32'h500); end
        step();
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    // ERROR response on an m1 read, then reset asserted in the middle of a write.
    task automatic test_error_reset();
        step();
        drive_m1(HTRANS_NONSEQ, 32'h600, 1'b0, 3'd0, 32'h0);
        #3;
        $display("txn m1 read 0x600 with ERROR response");
        checks++; if (s_if.haddr !== 32'h600) begin failures++; $display("FAIL er_haddr got=%h want=%h", s_if.haddr, 32'h600); end
        step();
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_slave(1'b0, 32'h0, 1'b1);
        #3;
        checks++; if (m1_if.hresp !== 1'b1 || m1_if.hready !== 1'b0) begin failures++; $display("FAIL er_cycle1 got=%b/%b want=1/0", m1_if.hresp, m1_if.hready); end
        checks++; if (m0_if.hresp !== 1'b0) begin failures++; $display("FAIL er_m0_hresp1 got=%b want=0", m0_if.hresp); end
        step();
        drive_slave(1'b1, 32'h0, 1'b1);
        #3;
        checks++; if (m1_if.hresp !== 1'b1 || m1_if.hready !== 1'b1) begin failures++; $display("FAIL er_cycle2 got=%b/%b want=1/1", m1_if.hresp, m1_if.hready); end
        checks++; if (m0_if.hresp !== 1'b0) begin failures++; $display("FAIL er_m0_hresp2 got=%b want=0", m0_if.hresp); end
        step();
        drive_slave(1'b1, 32'h0, 1'b0);
        drive_m1(HTRANS_NONSEQ, 32'h700, 1'b1, 3'd0, 32'h0);
        step();
        drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h1234_5678);
        drive_m0(HTRANS_NONSEQ, 32'h800, 1'b0, 3'd0, 32'h0);
        drive_slave(1'b0, 32'h0, 1'b1);
        #3;
        $display("txn m1 write 0x700 interrupted by reset");
        checks++; if (s_if.hwdata !== 32'h1234_5678 || m0_if.hready !== 1'b0) begin failures++; $display("FAIL er_pre_reset got=%h/%b want=%h/0", s_if.hwdata, m0_if.hready, 32'h1234_5678); end
        checks++; if (m1_if.hresp !== 1'b1) begin failures++; $display("FAIL er_pre_hresp got=%b want=1", m1_if.hresp); end
        #1;
        nrst = 1'b0;
        #1;
        checks++; if (s_if.hwdata !== 32'h0 || s_if.haddr !== 32'h0) begin failures++; $display("FAIL er_async_data got=%h/%h want=0/0", s_if.hwdata, s_if.haddr); end
        checks++; if (s_if.htrans !== HTRANS_IDLE || s_if.hwrite !== 1'b0) begin failures++; $display("FAIL er_async_ctrl got=%0d/%b want=%0d/0", s_if.htrans, s_if.hwrite, HTRANS_IDLE); end
        checks++; if (m0_if.hready !== 1'b1 || m1_if.hready !== 1'b1) begin failures++; $display("FAIL er_async_hready got=%b%b want=11", m0_if.hready, m1_if.hready); end
        checks++; if (m0_if.hresp !== 1'b0 || m1_if.hresp !== 1'b0) begin failures++; $display("FAIL er_async_hresp got=%b%b want=00", m0_if.hresp, m1_if.hresp); end
        step();
        step();
        drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_slave(1'b1, 32'h0, 1'b0);
        nrst = 1'b1;
        #3;
        checks++; if (s_if.htrans !== HTRANS_IDLE || s_if.hwdata !== 32'h0) begin failures++; $display("FAIL er_no_replay got=%0d/%h want=%0d/0", s_if.htrans, s_if.hwdata, HTRANS_IDLE); end
    endtask

    initial begin
        all_idle();
        nrst = 1'b1;
        #2;
        nrst = 1'b0;
        test_reset();
        test_single_read();
        test_alternation();
        test_fixed_priority();
        test_wait_states();
        test_burst();
        test_error_reset();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin, 0 = fixed priority with m0 winning.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port m0  ahb_bus_if.slave  bundle  requester 0 (instruction fetch).
REQ-005 SHALL have port m1  ahb_bus_if.slave  bundle  requester 1 (data).
REQ-006 SHALL have port s  ahb_bus_if.master  bundle  single shared downstream AHB-Lite bus.

Function
REQ-007 SHALL treat port i as requesting when its htrans is NONSEQ or SEQ; IDLE and BUSY are not requests.
REQ-008 SHALL hold a registered address grant ag (NONE/M0/M1), updated only on edges where s.hready=1; ag is frozen while s.hready=0.
REQ-009 SHALL compute next ag: one requester -> it; both -> the port not last granted (RR_EN=1) or m0 (RR_EN=0); none -> NONE.
REQ-010 SHALL NOT rearbitrate while the currently granted port drives htrans SEQ or BUSY; ag stays on that port.
REQ-011 SHALL drive s.haddr/hsize/hburst/htrans/hwrite from the port selected by the combinational next-grant; when NONE, drive htrans=IDLE and zeros on the others.
REQ-012 SHALL hold a data-phase owner register dp (NONE/M0/M1); on an edge with s.hready=1, dp <= granted port if its htrans was NONSEQ/SEQ, else NONE.
REQ-013 SHALL drive s.hwdata from the dp port, 0 when dp=NONE.
REQ-014 SHALL broadcast s.hrdata to both ports; hresp to the dp port only, 0 to the other.
REQ-015 SHALL drive port i hready: s.hready if i is dp or i is granted; 0 if i is requesting but not granted; 1 otherwise.
REQ-016 SHALL update last-granted register lg on every accepted NONSEQ address phase.
REQ-017 SHALL forward a two-cycle ERROR (hresp=1, hready 0 then 1) unchanged to the dp port; arbitration proceeds normally afterwards.
REQ-018 SHALL stall the losing port indefinitely (hready=0) while it requests; its held address is forwarded the cycle it wins.
REQ-019 SHALL allow pipelined overlap: one port in data phase while the other is in address phase.

Reset
REQ-020 SHALL, while nRST=0, force ag=NONE, dp=NONE, lg=M1 (m0 wins the first tie).
REQ-021 SHALL, in reset, drive s.htrans=IDLE, s.haddr=0, s.hwdata=0, s.hwrite=0, m0/m1 hready=1, hresp=0.
REQ-022 SHALL abandon any in-flight transfer on reset assertion mid-operation; no transfer is replayed after release.

Structure
REQ-023 SHALL define arb_owner_t enum {OWNER_NONE, OWNER_M0, OWNER_M1} in common_types_pkg; htrans_t is reused from it.
REQ-024 SHALL place two-input round-robin winner selection in sub-module ahb_rr_pick (inputs req[1:0], lg, en; output winner).
REQ-025 SHALL contain no data buffering; only the ag, dp and lg registers.

Verification
REQ-026 SHALL cover: m0 NONSEQ read 0x0000_0100, m1 idle, slave zero-wait -> s.haddr=0x100 same cycle, m0 hrdata valid next cycle, m0 hready=1 throughout.
REQ-027 SHALL cover: m0 and m1 NONSEQ together after reset -> m0 granted first, m1 hready=0 one cycle, m1 granted next; the following tie goes to m0 again (alternation).
REQ-028 SHALL cover: RR_EN=0 with both requesting continuously -> m0 always wins, m1 hready stays 0.
REQ-029 SHALL cover: m1 write 0xDEADBEEF to 0x2000 with slave inserting 2 wait states while m0 requests -> m0 address not on s until the cycle s.hready=1, s.hwdata=0xDEADBEEF held during the waits.
REQ-030 SHALL cover: m0 INCR4 burst (NONSEQ + 3 SEQ) with m1 requesting -> no m1 grant until the 4th beat is accepted.
REQ-031 SHALL cover: slave ERROR on an m1 read and nRST pulsed low mid-transfer -> hresp seen only on m1; on reset, outputs return to REQ-021 values immediately, asynchronously.
